alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Single-issue sequencer that sits directly upstream of the combinational ALU and also captures the ALU's output. It accepts one instruction per valid/ready handshake and reads operands from a small internal register file. It drives the ALU control, a and b inputs from registers, captures the result, carry and zero, writes the result back to the register file, and presents the result on a response handshake. It supplies the ALU with registered, glitch-free operands and gives the ALU a programmable register context.

Parameters:
WIDTH, 6, operand/result width; must equal the ALU width
NREG, 4, register-file depth; register 0 reads as zero; index width is clog2(NREG)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  block can accept an instruction
instr_op  in  4  ALU control code (AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000)
instr_rd  in  clog2(NREG)  destination register
instr_rs1  in  clog2(NREG)  source for operand a
instr_rs2  in  clog2(NREG)  source for operand b when imm_en=0
instr_imm_en  in  1  operand b taken from instr_imm
instr_imm  in  WIDTH  immediate operand b
alu_control  out  4  registered control to the ALU
alu_a  out  WIDTH  registered operand a
alu_b  out  WIDTH  registered operand b
alu_out  in  WIDTH  ALU result
alu_carry  in  1  ALU carry/borrow
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  WIDTH  captured result
rsp_carry  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_err  out  1  opcode was illegal
flag_carry  out  1  sticky status: carry of the last completed instruction
flag_zero  out  1  sticky status: zero of the last completed instruction

Behaviour:
- FSM states: IDLE, EXEC, WB.
- Reset (async, rst=1):
  - state=IDLE; all register-file entries=0.
  - alu_control/alu_a/alu_b=0; rsp_* =0; flag_*=0.
  - instr_ready=1 from the first cycle after rst deasserts.
- instr_ready = (state==IDLE). Combinational from state only; it has no dependency on instr_valid.
- IDLE -> EXEC on instr_valid & instr_ready. At that edge:
  - alu_control <= instr_op.
  - alu_a <= RF[rs1].
  - alu_b <= imm_en ? instr_imm : RF[rs2].
  - Any read of index 0 yields 0.
  - The illegal flag is latched: op not in the nine legal codes.
- EXEC lasts exactly 1 cycle; the ALU is combinational. At the end of EXEC:
  - Capture alu_out, alu_carry and alu_zero into rsp_result, rsp_carry, rsp_zero and flag_*.
  - Write RF[rd] <= alu_out, only if rd!=0 and the opcode is legal.
  - Go to WB.
- Illegal opcode:
  - rsp_result=0, rsp_carry=0, rsp_zero=1, rsp_err=1.
  - No RF write; flag_* unchanged.
- WB: rsp_valid=1. Result and flags are held stable until rsp_ready=1. WB -> IDLE on rsp_ready.
  - rsp_valid drops the cycle after acceptance.
  - rsp_* data retain their last values.
- Latency: accept edge T; EXEC during T+1; rsp_valid high in T+2 at the earliest. Throughput is at most 1 instruction per 3 cycles.
- alu_* outputs hold their last values outside EXEC. Only changing them on accept avoids toggling the ALU.
- Hazards: none, because the block is single-issue. The writeback completes before the next accept.
- Reset mid-EXEC/WB: the in-flight instruction is discarded and no writeback occurs if reset lands before the capture edge.
- Widths:
  - RF index width = clog2(NREG).
  - No arithmetic is performed in this block; all arithmetic belongs to the ALU.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit opcode localparams (AND..SLT) and a function is_legal_op(op);
  - the FSM state encoding;
  - the default WIDTH.
- The ALU also imports these constants.
- One sub-module: alu_regfile.
  - NREG x WIDTH registers with asynchronous reset.
  - 2 combinational read ports, with index 0 forced to zero.
  - 1 synchronous write port with write-enable; writes to index 0 are ignored.

Test Plan:
- Reset: hold rst 3 cycles, release -> instr_ready=1, rsp_valid=0, alu_a=alu_b=alu_control=0, flag_*=0.
- Load: ADD rd=1, rs1=0, imm_en=1, imm=0x25 -> rsp_valid 2 cycles after accept, rsp_result=0x25, carry=0, zero=0, err=0; RF[1]=0x25.
- Wrap: ADD rd=2, rs1=1, imm=0x1B -> result 0x00, carry=1, zero=1. Then SUB rd=3, rs1=0, imm=0x01 -> result 0x3F, carry=1.
- Shift/register operands: SRA rd=2, rs1=1, rs2=3 with RF[3] preloaded to 0x02 via ADD imm -> alu_b=0x02, result 0x39 (0x25 >>> 2).
- Backpressure and r0: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_result and rsp_carry/zero stay stable and instr_ready=0 throughout. Then ADD rd=0, imm=0x3F -> a later read of r0 gives alu_a=0.
- Illegal opcode and reset: op=1111 -> rsp_err=1, rsp_result=0, no RF write. Assert rst during EXEC of ADD rd=1 -> RF[1]=0 and rsp_valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check, sequencer
// state encoding and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 6;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  // True for the nine opcodes the ALU implements.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SLL, OP_XOR,
      OP_SRL, OP_SUB, OP_SRA, OP_SLT: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one synchronous write
// port. Entry 0 is hard-wired to zero, so writes to it are dropped.
module alu_regfile
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  parameter  int NREG  = 4,
  localparam int IDXW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDXW-1:0]  rd0_idx,
  output logic [WIDTH-1:0] rd0_data,
  input  logic [IDXW-1:0]  rd1_idx,
  output logic [WIDTH-1:0] rd1_data,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] rf_word [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
    if (gi == 0) begin : g_zero
      assign rf_word[gi] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] entry_reg;
      // Each entry loads on a matching write and clears on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (wr_en && (wr_idx == IDXW'(gi))) begin
          entry_reg <= wr_data;
        end
      end
      assign rf_word[gi] = entry_reg;
    end
  end

  assign rd0_data = rf_word[rd0_idx];
  assign rd1_data = rf_word[rd1_idx];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer in front of a combinational ALU: registers the ALU
// control and operands on accept, captures the ALU result one cycle later,
// writes it back and holds it on a response handshake.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  parameter  int NREG  = 4,
  localparam int IDXW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [IDXW-1:0]  instr_rd,
  input  logic [IDXW-1:0]  instr_rs1,
  input  logic [IDXW-1:0]  instr_rs2,
  input  logic             instr_imm_en,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             flag_carry,
  output logic             flag_zero
);

  state_t           state_reg;
  logic [IDXW-1:0]  rd_reg;
  logic             illegal_reg;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             wr_en;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd0_idx  (instr_rs1),
    .rd0_data (rs1_data),
    .rd1_idx  (instr_rs2),
    .rd1_data (rs2_data),
    .wr_en    (wr_en),
    .wr_idx   (rd_reg),
    .wr_data  (alu_out)
  );

  // Ready depends on state alone so the upstream never sees a combinational
  // path from its own valid back to ready.
  assign instr_ready = (state_reg == ST_IDLE);

  // Writeback happens on the capture edge at the end of EXEC.
  assign wr_en = (state_reg == ST_EXEC) && !illegal_reg && (rd_reg != '0);

  // Sequencer FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      rd_reg      <= '0;
      illegal_reg <= 1'b0;
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_carry   <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
      flag_carry  <= 1'b0;
      flag_zero   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // ALU inputs only move on accept, keeping the ALU quiet otherwise.
          if (instr_valid) begin
            alu_control <= instr_op;
            alu_a       <= rs1_data;
            alu_b       <= instr_imm_en ? instr_imm : rs2_data;
            rd_reg      <= instr_rd;
            illegal_reg <= !is_legal_op(instr_op);
            state_reg   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          if (illegal_reg) begin
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b1;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_out;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
            flag_carry <= alu_carry;
            flag_zero  <= alu_zero;
          end
          state_reg <= ST_WB;
        end
        ST_WB: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a behavioural ALU closes the loop, and a
// transaction-level model of the register file and response predicts every
// visible output, compared on each falling clock edge.
module tb_alu_issue_ctrl;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  logic [3:0]   instr_op;
  logic [1:0]   instr_rd;
  logic [1:0]   instr_rs1;
  logic [1:0]   instr_rs2;
  logic         instr_imm_en;
  logic [W-1:0] instr_imm;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         alu_carry;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_err;
  logic         flag_carry;
  logic         flag_zero;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_imm_en (instr_imm_en),
    .instr_imm    (instr_imm),
    .alu_control  (alu_control),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err),
    .flag_carry   (flag_carry),
    .flag_zero    (flag_zero)
  );

  // Behavioural ALU: returns {carry, result}; SUB carry is the borrow.
  function automatic logic [W:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W:0]          r;
    logic signed [W-1:0] sa;
    r  = '0;
    sa = $signed(a) >>> b[2:0];
    case (op)
      4'b0000: r = {1'b0, a & b};
      4'b0001: r = {1'b0, a | b};
      4'b0010: r = {1'b0, a} + {1'b0, b};
      4'b0011: r = {1'b0, a << b[2:0]};
      4'b0100: r = {1'b0, a ^ b};
      4'b0101: r = {1'b0, a >> b[2:0]};
      4'b0110: r = {1'b0, a} - {1'b0, b};
      4'b0111: r = {1'b0, sa};
      4'b1000: r = ($signed(a) < $signed(b)) ? (W+1)'(1) : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_control, alu_a, alu_b);
  assign alu_zero = (alu_out == '0);

  // Expected-state model
  logic [W-1:0] rf_model [4];
  logic         exp_ready, exp_rsp_valid, exp_carry, exp_zero, exp_err;
  logic         exp_fc, exp_fz;
  logic [3:0]   exp_ctrl;
  logic [W-1:0] exp_a, exp_b, exp_result;
  logic         chk_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rf_read(input int idx);
    return (idx == 0) ? '0 : rf_model[idx];
  endfunction

  task automatic exp_reset();
    for (int i = 0; i < 4; i++) rf_model[i] = '0;
    exp_ready = 1'b1; exp_rsp_valid = 1'b0;
    exp_ctrl = '0; exp_a = '0; exp_b = '0;
    exp_result = '0; exp_carry = 1'b0; exp_zero = 1'b0; exp_err = 1'b0;
    exp_fc = 1'b0; exp_fz = 1'b0;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_ready", instr_ready, exp_ready);
      chk("rsp_valid",   rsp_valid,   exp_rsp_valid);
      chk("alu_control", alu_control, exp_ctrl);
      chk("alu_a",       alu_a,       exp_a);
      chk("alu_b",       alu_b,       exp_b);
      chk("rsp_result",  rsp_result,  exp_result);
      chk("rsp_carry",   rsp_carry,   exp_carry);
      chk("rsp_zero",    rsp_zero,    exp_zero);
      chk("rsp_err",     rsp_err,     exp_err);
      chk("flag_carry",  flag_carry,  exp_fc);
      chk("flag_zero",   flag_zero,   exp_fz);
    end
  end

  // Issue one instruction, let it execute, hold the response for 'hold'
  // cycles of backpressure, then accept it. Called at posedge+1.
  task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                       input logic imm_en, input logic [W-1:0] imm, input int hold);
    int         guard;
    logic [W:0] r;
    logic       legal;
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!instr_ready) begin
      checks++; failures++;
      $display("FAIL issue_wait actual=busy required=ready");
      return;
    end
    instr_op = op; instr_rd = 2'(rd); instr_rs1 = 2'(rs1); instr_rs2 = 2'(rs2);
    instr_imm_en = imm_en; instr_imm = imm; instr_valid = 1'b1;
    @(posedge clk); #1;                       // accept edge
    instr_valid = 1'b0;
    exp_ready = 1'b0;
    exp_ctrl  = op;
    exp_a     = rf_read(rs1);
    exp_b     = imm_en ? imm : rf_read(rs2);
    @(posedge clk); #1;                       // capture edge, end of EXEC
    legal = (op <= 4'd8);
    exp_rsp_valid = 1'b1;
    if (legal) begin
      r = alu_fn(op, exp_a, exp_b);
      exp_result = r[W-1:0]; exp_carry = r[W]; exp_zero = (r[W-1:0] == '0); exp_err = 1'b0;
      exp_fc = exp_carry; exp_fz = exp_zero;
      if (rd != 0) rf_model[rd] = r[W-1:0];
    end else begin
      exp_result = '0; exp_carry = 1'b0; exp_zero = 1'b1; exp_err = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;                       // response accepted
    rsp_ready = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_ready = 1'b1;
    $display("txn op=%h rd=%0d a=%h b=%h result=%h carry=%b zero=%b err=%b",
             op, rd, alu_a, alu_b, rsp_result, rsp_carry, rsp_zero, rsp_err);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    instr_imm_en = 1'b0; instr_imm = '0; rsp_ready = 1'b0;
    exp_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", instr_ready, 1);

    // Load: r1 = 0 + 0x25
    issue(4'b0010, 1, 0, 0, 1'b1, 6'h25, 0);
    chk("load_result", rsp_result, 6'h25);
    chk("load_carry",  rsp_carry,  0);

    // Wrap: r2 = r1 + 0x1B -> 0 with carry
    issue(4'b0010, 2, 1, 0, 1'b1, 6'h1B, 0);
    chk("wrap_a",      alu_a,      6'h25);
    chk("wrap_result", rsp_result, 6'h00);
    chk("wrap_carry",  rsp_carry,  1);
    chk("wrap_zero",   rsp_zero,   1);

    // SUB borrow: r3 = 0 - 1
    issue(4'b0110, 3, 0, 0, 1'b1, 6'h01, 0);
    chk("sub_result", rsp_result, 6'h3F);
    chk("sub_carry",  rsp_carry,  1);

    // Preload r3 = 2, then SRA r2 = r1 >>> r3 under 5 cycles of backpressure
    issue(4'b0010, 3, 0, 0, 1'b1, 6'h02, 0);
    issue(4'b0111, 2, 1, 3, 1'b0, 6'h00, 5);
    chk("sra_b",      alu_b,      6'h02);
    chk("sra_result", rsp_result, 6'h39);

    // Write to r0 is dropped; later read of r0 yields 0
    issue(4'b0010, 0, 0, 0, 1'b1, 6'h3F, 0);
    issue(4'b0100, 3, 0, 2, 1'b0, 6'h00, 1);
    chk("r0_read_a",  alu_a,      6'h00);
    chk("xor_result", rsp_result, 6'h39);

    // Illegal opcode: error response, no writeback, flags kept
    issue(4'b1111, 1, 1, 0, 1'b1, 6'h05, 0);
    chk("illegal_err",    rsp_err,    1);
    chk("illegal_result", rsp_result, 6'h00);
    chk("illegal_fzero",  flag_zero,  0);
    issue(4'b1000, 2, 1, 0, 1'b1, 6'h01, 0);
    chk("illegal_no_wb", alu_a,      6'h25);
    chk("slt_result",    rsp_result, 6'h01);
    issue(4'b0000, 2, 1, 3, 1'b0, 6'h00, 2);
    chk("and_result", rsp_result, 6'h21);

    // Reset during EXEC of ADD r1 = 0x11: discarded, RF cleared
    instr_op = 4'b0010; instr_rd = 2'd1; instr_rs1 = 2'd0; instr_imm_en = 1'b1;
    instr_imm = 6'h11; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    exp_ready = 1'b0; exp_ctrl = 4'b0010; exp_a = '0; exp_b = 6'h11;
    #2 rst = 1'b1;
    #1 exp_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rsp_valid", rsp_valid, 0);
    issue(4'b0010, 2, 1, 0, 1'b1, 6'h00, 0);
    chk("rst_r1_cleared", alu_a, 6'h00);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
